multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM of the multicycle MIPS datapath. Sits directly upstream of the register file.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the register-file write enable and destination select, plus all PC, IR, memory and ALU mux controls.
- Handles a variable-latency memory handshake and halts on an illegal opcode.

Parameters:
- OPW, 6, opcode and funct width
- STW, 4, state register width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- opcode  in  OPW  IR[31:26]
- funct  in  OPW  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  request is a write (valid with mem_req)
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- ir_write  out  1  load IR
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- pc_source  out  2  0 = ALU, 1 = ALUOut, 2 = jump target
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2
- alu_op  out  2  0 = add, 1 = sub, 2 = funct-decoded
- reg_write  out  1  register-file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- halted  out  1  FSM in HALT
- state  out  STW  current state (debug)

Behaviour:
- States: IF=0, ID=1, MADDR=2, MRD=3, MWB=4, MWR=5, REXE=6, RWB=7, BEQ=8, JMP=9, IEXE=10, IWB=11, HALT=12.
- Reset: state = IF. All outputs 0 except the combinational decode of IF, with every enable gated by mem_ready.
- Outputs are Moore decodes of state. Exceptions: ir_write, pc_write in IF, and state advance out of IF/MRD/MWR are qualified by mem_ready (Mealy).
- IF:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - ir_write = pc_write = mem_ready.
  - Hold in IF until mem_ready, then go to ID.
- ID:
  - alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut).
  - Dispatch on opcode:
    - 000000 -> REXE
    - 100011 or 101011 -> MADDR
    - 000100 -> BEQ
    - 000010 -> JMP
    - 001000 -> IEXE
    - anything else -> HALT
- MADDR: alu_src_a=1, alu_src_b=2, alu_op=0. lw -> MRD, sw -> MWR.
- MRD: mem_req=1, iord=1. Wait for mem_ready, then -> MWB.
- MWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> IF.
- MWR: mem_req=1, mem_write=1, iord=1. Wait for mem_ready, then -> IF.
- REXE: alu_src_a=1, alu_src_b=0, alu_op=2 -> RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> IF.
- BEQ: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1 -> IF.
- JMP: pc_write=1, pc_source=2 -> IF.
- IEXE: alu_src_a=1, alu_src_b=2, alu_op=0 -> IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> IF.
- HALT: all enables 0, halted=1. Left only by reset.
- Funct:
  - Used only for the R-type with funct=000000 and opcode=000000 (nop). It still runs REXE/RWB; the register file discards writes to $0.
  - An unsupported funct is not trapped.
- reg_write is asserted for exactly one cycle per writing instruction.
- mem_req is held high continuously through a wait. It never pulses between wait cycles.
- mem_ready outside IF/MRD/MWR is ignored.
- Reset asserted mid-instruction: immediate return to IF. No write enable may glitch high while reset is low.
- Unreachable state encodings (13-15) -> HALT on the next edge.
- Cycle counts with zero-wait memory:
  - R-type, addi: 4
  - lw: 5
  - sw: 4
  - beq, j: 3

Optional Feature:
- Macro MULTICYCLE_CTRL_PERF_EN.
- When defined:
  - Adds outputs cycle_count[31:0] and instr_count[31:0], both reset to 0.
  - cycle_count increments every non-HALT cycle.
  - instr_count increments on every transition into IF from a non-IF state.
  - Both wrap from 0xFFFFFFFF to 0 silently.
- When undefined: the ports and logic are absent. Core behaviour is identical.

Decomposition:
- Package multicycle_pkg:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - alu_op, alu_src_b and pc_source encodings
- One natural sub-module, multicycle_perf_counter, instantiated only under MULTICYCLE_CTRL_PERF_EN.

Test Plan:
- Reset low, then high with mem_ready=1, opcode=000000 -> states IF,ID,REXE,RWB,IF. reg_write=1 only in RWB, reg_dst=1.
- lw (100011) with mem_ready low for 3 cycles in MRD -> mem_req=1 held 4 cycles; MWB reached after mem_ready; mem_to_reg=1, reg_write pulses once.
- beq (000100) with zero=1 -> BEQ state shows pc_write_cond=1, pc_source=1, alu_op=1; back to IF on the next edge. Total 3 cycles.
- opcode=111111 -> ID->HALT. halted=1, all enables 0 for 20 cycles. Reset low -> state=0 asynchronously.
- Reset dropped low during MWR with mem_req high -> state=0 immediately; mem_write and reg_write never go high afterwards until IF.
- With MULTICYCLE_CTRL_PERF_EN and zero-wait memory, run sequence addi, sw, j -> instr_count=3, cycle_count=11.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes, mux selects.
// No logic, so no latency or backpressure behaviour.
// The opcode dispatch helper is shared by the FSM's ID state.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_MWB   = 4'd4,
        S_MWR   = 4'd5,
        S_REXE  = 4'd6,
        S_RWB   = 4'd7,
        S_BEQ   = 4'd8,
        S_JMP   = 4'd9,
        S_IEXE  = 4'd10,
        S_IWB   = 4'd11,
        S_HALT  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Unsupported opcodes fall through to HALT; there is no trap path.
    function automatic state_t decode_opcode(input logic [5:0] op);
        case (op)
            OP_RTYPE:     return S_REXE;
            OP_LW, OP_SW: return S_MADDR;
            OP_BEQ:       return S_BEQ;
            OP_J:         return S_JMP;
            OP_ADDI:      return S_IEXE;
            default:      return S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_perf_counter.sv
// Cycle and retired-instruction counters, present only with MULTICYCLE_CTRL_PERF_EN.
// Counts update on the edge after the qualifying cycle; both wrap silently.
// No backpressure: increments are single-cycle strobes from the control FSM.
`ifdef MULTICYCLE_CTRL_PERF_EN
module multicycle_perf_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        cycle_inc,
    input  logic        instr_inc,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (cycle_inc) cycle_count <= cycle_count + 32'd1;
            if (instr_inc) instr_count <= instr_count + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath; optional counters via MULTICYCLE_CTRL_PERF_EN.
// Moore decode of state, except ir_write/pc_write in IF which follow mem_ready combinationally.
// Stalls in IF/MRD/MWR with mem_req held high until mem_ready; HALT is left only by reset.
module multicycle_control #(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] funct,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           mem_write,
    output logic           iord,
    output logic           ir_write,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic [1:0]     pc_source,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic           reg_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           halted,
    output logic [STW-1:0] state
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]    cycle_count,
    output logic [31:0]    instr_count
`else
    // core-only build: no counter ports
`endif
);

    import multicycle_pkg::*;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op6;

    assign op6   = 6'(opcode);
    assign state = STW'(state_q);

    // funct is decoded by ALU control and zero gates pc_write_cond in the datapath;
    // neither steers this FSM.
    logic unused_inputs;
    assign unused_inputs = ^{funct, zero};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        halted        = 1'b0;

        case (state_q)
            S_IF: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                // Speculatively form the branch target into ALUOut.
                alu_src_b = SRCB_IMM_SH;
                state_d   = decode_opcode(op6);
            end
            S_MADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (op6 == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MWB;
            end
            S_MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_IF;
            end
            S_MWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_IF;
            end
            S_REXE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_IF;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_d       = S_IF;
            end
            S_JMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_d   = S_IF;
            end
            S_IEXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
                state_d   = S_IF;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            // Encodings 13-15 are unreachable; recover into HALT.
            default: state_d = S_HALT;
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    multicycle_perf_counter u_perf (
        .clock       (clock),
        .reset       (reset),
        .cycle_inc   (state_q != S_HALT),
        .instr_inc   ((state_q != S_IF) && (state_d == S_IF)),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );
`else
    // counters absent in the core-only build
`endif

endmodule
